seg_message_scroller: RTL and testbench
=======================================

Name: seg_message_scroller

Overview:
- Upstream feeder for the 4-digit 7-segment display controller: produces its 20-bit `seg_data` word (4 x 5-bit character codes).
- Holds a short message of character codes in a small register file, written by the system FSM.
- On command, scrolls the message right-to-left across the 4 digits at a programmable step rate, once or looping.
- Signals busy/done back to the controlling FSM.

Parameters:
- ADDR_W, 4, message address width; MAX_LEN = 2**ADDR_W characters (default 16).
- STEP_DIV, 25000000, clk cycles per scroll step (0.25 s at 100 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for message storage.
- wr_addr  input  ADDR_W  character slot written when wr_en=1.
- wr_char  input  5  character code written (0-9 digits, 10 '-', 11 E, 12 r, 13 L, 14 H, 15 U, 16 P, 17 o, 18 b, 19 d, 20 n, 21 J, 22 y, 30 h, 31 blank).
- msg_len  input  ADDR_W+1  message length; sampled on accepted start.
- loop  input  1  1 = repeat passes indefinitely; sampled on accepted start.
- start  input  1  single-cycle start/restart command.
- stop  input  1  single-cycle abort command.
- seg_data  output  20  display word; [19:15] leftmost digit ... [4:0] rightmost digit; registered.
- busy  output  1  high while in SCROLL.
- done  output  1  one-cycle pulse at end of a non-looping pass.

Behaviour:
- Reset:
  - `seg_data` = 20'hFFFFF (all blank, code 31); `busy` = 0; `done` = 0.
  - state = IDLE; pos = 0; prescaler = 0; len_q = 0; loop_q = 0.
  - Message storage is NOT reset (contents undefined until written).
- Storage:
  - MAX_LEN x 5-bit register file; written on any cycle wr_en=1, in any state.
  - Writes take effect on the next edge; a write to a visible slot appears on `seg_data` one cycle after the write edge.
- len_q = min(msg_len, MAX_LEN), captured on accepted start.
- States: IDLE, SCROLL.
- IDLE:
  - `seg_data` all blank; `busy` = 0.
  - start=1 and msg_len!=0 -> SCROLL; pos = 0; prescaler = 0; len_q and loop_q captured.
  - start with msg_len=0 is ignored: stay IDLE, no done.
- SCROLL:
  - Prescaler counts 0..STEP_DIV-1; step = (prescaler == STEP_DIV-1), then the prescaler wraps to 0.
  - On step with pos < len_q+3: pos <= pos+1.
  - On step with pos == len_q+3 and loop_q=1: pos <= 0, stay in SCROLL.
  - On step with pos == len_q+3 and loop_q=0: -> IDLE; `done` = 1 for that one cycle (registered, visible the cycle after the step edge).
  - One pass = len_q+4 steps = (len_q+4)*STEP_DIV cycles from the start edge to the done edge.
- Window mapping: slot d = 0 (leftmost) .. 3 (rightmost); k = pos + d - 3.
  - Slot char = msg[k] if 0 <= k < len_q, else 31.
  - pos = 0 shows msg[0] in the rightmost digit only.
  - pos = len_q+3 shows all blank.
- `seg_data` is registered from current state/pos/storage, so it lags state/pos by one cycle.
  - First window (pos 0) is visible from cycle T+2, where start is sampled at edge T.
- Priority per cycle: reset > stop > start > step.
  - stop in SCROLL -> IDLE, blank next cycle, no done.
  - stop in IDLE: no effect.
  - start in SCROLL (stop=0, msg_len!=0): restart at pos 0, prescaler 0, new len_q/loop_q; a coincident step is discarded.
  - start in SCROLL with msg_len=0: ignored; scroll continues.
- Reset mid-scroll: immediate return to reset values on that edge; no done.
- Width rules: pos is ADDR_W+2 bits (max MAX_LEN+3 = 19 fits in 6 bits at default); all compares unsigned.

Test Plan:
- Reset asserted mid-operation -> next cycle `seg_data` = 20'hFFFFF, `busy` = 0, `done` = 0.
- STEP_DIV=4; write "HELP" (14,11,13,16) to addr 0-3; msg_len=4, loop=0, start:
  - window sequence {31,31,31,14}, {31,31,14,11}, {31,14,11,13}, {14,11,13,16}, {11,13,16,31}, {13,16,31,31}, {16,31,31,31}, {31,31,31,31}, each held 4 cycles;
  - `done` pulses once 32 cycles after the start edge; `busy` falls with it.
- Same as above with loop=1 -> after the all-blank window, {31,31,31,14} reappears; `done` never asserts over 3 passes.
- stop during window {14,11,13,16} -> blank the following cycle, `busy` = 0, no `done` pulse.
- Length edge cases:
  - msg_len=0 with start -> no state change, `busy` stays 0.
  - msg_len=20 -> len_q = 16; pass lasts 20 steps.
- Mid-scroll events:
  - Write code 0 to addr 1 while 'E' is visible -> that digit shows 0 one cycle later.
  - start asserted on a step cycle -> restarts at pos 0; the step is discarded.

Source files
------------

// File: rtl/seg_message_scroller_if.sv
// rtl/seg_message_scroller_if.sv - message write, scroll control and display-word bundle
// The controlling FSM drives the master side; the scroller uses the slave side.
interface seg_message_scroller_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [4:0]        wr_char;
  logic [ADDR_W:0]   msg_len;
  logic              loop;
  logic              start;
  logic              stop;
  logic [19:0]       seg_data;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_char, msg_len, loop, start, stop,
    input  seg_data, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, msg_len, loop, start, stop,
    output seg_data, busy, done
  );
endinterface

// File: rtl/seg_message_scroller.sv
// rtl/seg_message_scroller.sv - scrolls a stored character message across a 4-digit display
// Message enters at the rightmost digit and exits on the left; one pass ends on an all-blank window.
module seg_message_scroller #(
  parameter int ADDR_W   = 4,
  parameter int STEP_DIV = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  seg_message_scroller_if.slave  bus
);
  localparam int MAX_LEN = 1 << ADDR_W;
  localparam int PW      = $clog2(STEP_DIV);
  localparam int POS_W   = ADDR_W + 2;
  localparam int K_W     = ADDR_W + 3;

  typedef enum logic {IDLE, SCROLL} state_e;

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;
  logic [19:0]       seg_q, seg_d;
  logic [4:0]        mem_q [MAX_LEN];

  logic              step;
  logic [POS_W-1:0]  last_pos;
  logic [K_W-1:0]    k;

  assign step     = (presc_q == PW'(STEP_DIV - 1));
  assign last_pos = {1'b0, len_q} + POS_W'(3);

  // Storage is deliberately left unreset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_char;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    if (bus.stop && state_q == SCROLL) begin
      state_d = IDLE;
    end else if (bus.start && bus.msg_len != '0) begin
      state_d = SCROLL;
      pos_d   = '0;
      presc_d = '0;
      len_d   = (bus.msg_len > (ADDR_W+1)'(MAX_LEN)) ? (ADDR_W+1)'(MAX_LEN) : bus.msg_len;
      loop_d  = bus.loop;
    end else if (state_q == SCROLL) begin
      if (step) begin
        presc_d = '0;
        if (pos_q < last_pos) begin
          pos_d = pos_q + POS_W'(1);
        end else if (loop_q) begin
          pos_d = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Slot d shows msg[pos+d-3]; a negative index wraps high and fails the length test.
  always_comb begin
    seg_d = '1;
    k     = '0;
    for (int d = 0; d < 4; d++) begin
      k = {1'b0, pos_q} + K_W'(d) - K_W'(3);
      if (state_q == SCROLL && k < {2'b00, len_q}) begin
        seg_d[5*(3-d) +: 5] = mem_q[k[ADDR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      presc_q <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.seg_data = seg_q;
  assign bus.busy     = (state_q == SCROLL);
  assign bus.done     = done_q;
endmodule

// File: tb/tb_seg_message_scroller.sv
// tb/tb_seg_message_scroller.sv - scoreboard bench for seg_message_scroller
// Expected display/busy/done per cycle are queued at each start and popped as cycles elapse.
module tb_seg_message_scroller;
  localparam int S     = 4;
  localparam int ADDRW = 4;
  localparam logic [19:0] BLANK = 20'hFFFFF;

  typedef struct {
    logic [19:0] seg;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [4:0] msg [16];
  exp_t sb [$];

  always #5 clk = ~clk;

  seg_message_scroller_if #(.ADDR_W(ADDRW)) bus ();

  seg_message_scroller #(.ADDR_W(ADDRW), .STEP_DIV(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] win(input int w, input int len);
    logic [19:0] r;
    int k;
    r = BLANK;
    for (int d = 0; d < 4; d++) begin
      k = w + d - 3;
      if (k >= 0 && k < len) r[19-5*d -: 5] = msg[k];
    end
    return r;
  endfunction

  function automatic exp_t expect_at(input int n, input int len, input bit lp, input logic [19:0] seg0);
    exp_t e;
    int   pass_cyc;
    pass_cyc = (len + 4) * S;
    if (n == 0) begin
      e.seg = seg0; e.busy = 1'b1; e.done = 1'b0;
    end else if (lp) begin
      e.seg = win(((n - 1) / S) % (len + 4), len); e.busy = 1'b1; e.done = 1'b0;
    end else begin
      e.busy = (n < pass_cyc);
      e.done = (n == pass_cyc);
      e.seg  = (n - 1 < pass_cyc) ? win((n - 1) / S, len) : BLANK;
    end
    return e;
  endfunction

  task automatic wr(input int addr, input logic [4:0] ch);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = addr[ADDRW-1:0]; bus.wr_char = ch;
    msg[addr] = ch;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Leaves the bench at the negedge following edge T+ncyc-1, where T samples start.
  task automatic go(input int len, input bit lp, input int ncyc, input logic [19:0] seg0);
    int   leff;
    exp_t e;
    leff = (len > 16) ? 16 : len;
    @(negedge clk);
    bus.start = 1'b1; bus.msg_len = len[ADDRW:0]; bus.loop = lp;
    for (int n = 0; n < ncyc; n++) sb.push_back(expect_at(n, leff, lp, seg0));
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      e = sb.pop_front();
      check_eq("seg", {12'd0, bus.seg_data}, {12'd0, e.seg});
      check_eq("busy", {31'd0, bus.busy}, {31'd0, e.busy});
      check_eq("done", {31'd0, bus.done}, {31'd0, e.done});
    end
  endtask

  task automatic stop_and_settle();
    @(negedge clk); bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    check_eq("stop_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check_eq("stop_seg", {12'd0, bus.seg_data}, {12'd0, BLANK});
    check_eq("stop_done", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_char = '0;
    bus.msg_len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    for (int i = 0; i < 16; i++) msg[i] = 5'd31;
    repeat (3) @(negedge clk);
    check_eq("rst_seg", {12'd0, bus.seg_data}, {12'd0, BLANK});
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;

    wr(0, 5'd14); wr(1, 5'd11); wr(2, 5'd13); wr(3, 5'd16);

    // Single pass of HELP, then one idle cycle.
    go(4, 1'b0, 34, BLANK);

    // Looping over three passes, no done expected.
    go(4, 1'b1, 3 * 32 + 6, BLANK);
    stop_and_settle();

    // Stop while the full word is on display.
    go(4, 1'b0, 14, BLANK);
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("abort_done0", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check_eq("abort_seg", {12'd0, bus.seg_data}, {12'd0, BLANK});
    check_eq("abort_done1", {31'd0, bus.done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_nodone", {31'd0, bus.done}, 32'd0);
    end

    // Overwrite the visible 'E' with '0'.
    go(4, 1'b0, 14, BLANK);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_char = 5'd0;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check_eq("wr_before", {12'd0, bus.seg_data}, {12'd0, 20'hFFFFF & {5'd14, 5'd11, 5'd13, 5'd16}});
    @(negedge clk);
    check_eq("wr_after", {12'd0, bus.seg_data}, {12'd0, 20'hFFFFF & {5'd14, 5'd0, 5'd13, 5'd16}});
    stop_and_settle();
    wr(1, 5'd11);

    // Restart coinciding with a step edge: pass timing restarts from pos 0.
    go(4, 1'b0, 7, BLANK);
    go(4, 1'b0, 34, win(1, 4));

    // Zero-length start is ignored.
    @(negedge clk); bus.start = 1'b1; bus.msg_len = '0;
    @(negedge clk); bus.start = 1'b0;
    check_eq("len0_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("len0_seg", {12'd0, bus.seg_data}, {12'd0, BLANK});
    @(negedge clk);
    check_eq("len0_busy2", {31'd0, bus.busy}, 32'd0);
    check_eq("len0_done", {31'd0, bus.done}, 32'd0);

    // Over-length request clamps to 16 characters.
    for (int i = 0; i < 16; i++) wr(i, 5'((5 * i + 1) % 23));
    go(20, 1'b0, 20 * S + 2, BLANK);

    // Reset in the middle of a pass.
    go(4, 1'b0, 10, BLANK);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mrst_seg", {12'd0, bus.seg_data}, {12'd0, BLANK});
    check_eq("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("mrst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("mrst_idle", {31'd0, bus.busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
